bus_timer: RTL and testbench
============================

// Module: bus_timer
// PURPOSE
//  Memory-mapped timer on the shared 8-bit CPU bus (BUS_DATA/BUS_ADDR/BUS_WE), in high memory above the 128-byte RAM.
//  Prescales CLK into ticks and counts ticks up to a programmable period.
//  On expiry it sets a sticky flag and optionally raises a CPU interrupt with a raise/ack handshake.
//  Bus read timing is identical to the data RAM: registered data, registered drive enable.
// PARAMETERS
//  BASE_ADDR       8'hF0   base of a 4-byte register window (BASE..BASE+3); BASE[1:0] must be 0
//  PRESCALE        100000  CLK cycles per tick (1 ms at 100 MHz); must be >= 2
//  PRESCALE_WIDTH  17      width of the prescaler counter; 2**PRESCALE_WIDTH must be >= PRESCALE
// PORTS
//  CLK                  in     1  system clock; all state changes on the rising edge
//  RESET                in     1  asynchronous, active-low reset
//  BUS_DATA             inout  8  shared data bus; driven only during a read of this window, else 8'hZZ
//  BUS_ADDR             in     8  bus address
//  BUS_WE               in     1  1 = CPU write, 0 = read
//  BUS_INTERRUPT_RAISE  out    1  interrupt request, level, held until acknowledged
//  BUS_INTERRUPT_ACK    in     1  CPU acknowledge, 1-cycle pulse
// BEHAVIOUR
//  Register map, offset = BUS_ADDR - BASE_ADDR:
//   0 CTRL   R/W  [0]=EN  [1]=IRQ_EN  [2]=AUTO_RELOAD  [7:3] read 0
//   1 PERIOD R/W  8-bit tick count per expiry; 0 means 256
//   2 COUNT  R    current tick count. Any write clears COUNT and the prescaler.
//   3 STATUS R/W1C  [0]=EXP (sticky expiry flag). Writing 1 to bit 0 clears it.
//  Bus read timing, evaluated each edge:
//   If the address is in the window and BUS_WE=0: drive_en<=1 and out<=register.
//   Otherwise drive_en<=0.
//   Data is therefore valid on BUS_DATA from the edge after the address is presented.
//  Writes take effect on the edge at which BUS_WE=1 with the address in the window.
//  Prescaler, only while EN=1:
//   presc counts 0..PRESCALE-1 and then wraps to 0.
//   tick = EN && presc==PRESCALE-1.
//  On a tick:
//   If COUNT==PERIOD-1 (8-bit wrap, so PERIOD=0 gives 256 ticks) this is an expiry:
//    COUNT<=0 and EXP<=1.
//    If IRQ_EN=1, RAISE<=1.
//    If AUTO_RELOAD=0, EN<=0 (one-shot).
//   Otherwise COUNT<=COUNT+1.
//  A CTRL write taking EN from 0 to 1 clears presc and COUNT on the same edge.
//  A CTRL write with EN=0 freezes presc and COUNT at their current values.
//  Interrupt handshake:
//   RAISE is set on an expiry when IRQ_EN=1.
//   RAISE clears on the edge at which ACK=1 is sampled.
//   RAISE also clears when IRQ_EN is written 0.
//   ACK while RAISE=0 is ignored.
//  Simultaneous events:
//   ACK and a new expiry on the same edge: RAISE stays 1, because the new event wins.
//   W1C of EXP and an expiry on the same edge: EXP=1.
//   COUNT write and a tick on the same edge: the write wins, COUNT=0 and there is no expiry.
//   PERIOD write during counting: the new value applies to the next tick comparison.
//  Reset, asynchronous and also mid-operation:
//   CTRL, PERIOD, COUNT, presc, EXP, RAISE, out and drive_en all go to 0.
//   BUS_DATA goes to Z immediately.
// TESTING  (bench uses PRESCALE=4)
//  1. Assert RESET=0 mid-count with a read active -> RAISE=0, BUS_DATA=Z in the same cycle; all registers read 0 after release.
//  2. Write PERIOD=3, then CTRL=0x07 at edge E0 -> ticks at E4, E8, E12; RAISE=1 after E12; COUNT reads 0 after E12.
//  3. From case 2, pulse ACK for 1 cycle -> RAISE=0 after that edge; STATUS reads 0x01; write STATUS=0x01 -> STATUS reads 0x00.
//  4. Read BUS_ADDR=0xF1 -> BUS_DATA=0x03 from the next edge; then BUS_ADDR=0x10 -> BUS_DATA=Z after the next edge, leaving the RAM free to drive.
//  5. PERIOD=2, CTRL=0x03 (one-shot) -> one RAISE after 8 edges; CTRL then reads 0x02; no further RAISE over 100 cycles.
//  6. PERIOD=1, CTRL=0x07, ACK asserted on an expiry edge -> RAISE remains 1; PERIOD=0 -> expiry every 1024 cycles.

Source files
------------

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled tick timer on the shared 8-bit CPU bus.
//
// A prescaler divides CLK into ticks. COUNT counts ticks up to PERIOD. On expiry the
// sticky EXP flag is set, and BUS_INTERRUPT_RAISE is optionally raised until the CPU
// acknowledges it. Read data is registered and driven one edge after the address is
// presented, with the same timing as the data RAM.
//
// Register window (offset from BASE_ADDR):
//   0 CTRL   R/W   [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD, [7:3] read 0
//   1 PERIOD R/W   ticks per expiry, 0 means 256
//   2 COUNT  R     current tick count; any write clears COUNT and the prescaler
//   3 STATUS R/W1C [0] EXP sticky expiry flag
//
// Ports:
//   CLK                 in    system clock, rising edge
//   RESET               in    asynchronous active-low reset
//   BUS_DATA            inout shared data bus, driven only for reads of this window
//   BUS_ADDR            in    bus address
//   BUS_WE              in    1 = write, 0 = read
//   BUS_INTERRUPT_RAISE out   level interrupt request, held until acknowledged
//   BUS_INTERRUPT_ACK   in    one-cycle acknowledge pulse
module bus_timer #(
  parameter logic [7:0]  BASE_ADDR      = 8'hF0,
  parameter int unsigned PRESCALE       = 100000,
  parameter int unsigned PRESCALE_WIDTH = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [PRESCALE_WIDTH-1:0] PRESC_LAST = PRESCALE_WIDTH'(PRESCALE - 1);
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE  = PRESCALE_WIDTH'(1);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic                      en_q, en_d;
  logic                      irq_en_q, irq_en_d;
  logic                      auto_q, auto_d;
  logic [7:0]                period_q, period_d;
  logic [7:0]                count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      exp_q, exp_d;
  logic                      raise_q, raise_d;
  logic [7:0]                out_q, out_d;
  logic                      drive_q, drive_d;

  logic       in_win, rd, wr;
  logic       ctrl_wr, period_wr, count_wr, status_wr;
  logic [7:0] wdata, rdata;
  logic       presc_last, tick, tick_eff, freeze, start, expire;

  assign in_win    = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign rd        = in_win & ~BUS_WE;
  assign wr        = in_win & BUS_WE;
  assign ctrl_wr   = wr && (BUS_ADDR[1:0] == OFF_CTRL);
  assign period_wr = wr && (BUS_ADDR[1:0] == OFF_PERIOD);
  assign count_wr  = wr && (BUS_ADDR[1:0] == OFF_COUNT);
  assign status_wr = wr && (BUS_ADDR[1:0] == OFF_STATUS);
  assign wdata     = BUS_DATA;

  assign presc_last = (presc_q == PRESC_LAST);
  assign tick       = en_q && presc_last;
  // A CTRL write with EN=0 freezes the counters even on a tick edge.
  assign freeze     = ctrl_wr && !wdata[0];
  assign start      = ctrl_wr && wdata[0] && !en_q;
  // A COUNT write beats a coincident tick: no increment and no expiry.
  assign tick_eff   = tick && !count_wr && !freeze;
  // 8-bit wrap makes PERIOD=0 compare against 255, i.e. 256 ticks.
  assign expire     = tick_eff && (count_q == (period_q - 8'd1));

  always_comb begin
    unique case (BUS_ADDR[1:0])
      OFF_CTRL:   rdata = {5'b0, auto_q, irq_en_q, en_q};
      OFF_PERIOD: rdata = period_q;
      OFF_COUNT:  rdata = count_q;
      default:    rdata = {7'b0, exp_q};
    endcase
  end

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    auto_d   = auto_q;
    period_d = period_q;
    count_d  = count_q;
    presc_d  = presc_q;
    exp_d    = exp_q;
    raise_d  = raise_q;
    out_d    = out_q;
    drive_d  = rd;

    if (rd) out_d = rdata;

    // Prescaler
    if (count_wr || start) begin
      presc_d = '0;
    end else if (en_q && !freeze) begin
      presc_d = presc_last ? '0 : presc_q + PRESC_ONE;
    end

    // Tick counter
    if (count_wr || start) begin
      count_d = 8'd0;
    end else if (tick_eff) begin
      count_d = expire ? 8'd0 : count_q + 8'd1;
    end

    // One-shot expiry stops the timer; a coincident CTRL write takes priority.
    if (expire && !auto_q) en_d = 1'b0;
    if (ctrl_wr) begin
      en_d     = wdata[0];
      irq_en_d = wdata[1];
      auto_d   = wdata[2];
    end

    if (period_wr) period_d = wdata;

    // Expiry wins over a coincident W1C.
    if (status_wr && wdata[0]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;

    // Expiry wins over a coincident ACK or IRQ_EN clear.
    if (BUS_INTERRUPT_ACK) raise_d = 1'b0;
    if (ctrl_wr && !wdata[1]) raise_d = 1'b0;
    if (expire && irq_en_q) raise_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      auto_q   <= 1'b0;
      period_q <= 8'd0;
      count_q  <= 8'd0;
      presc_q  <= '0;
      exp_q    <= 1'b0;
      raise_q  <= 1'b0;
      out_q    <= 8'd0;
      drive_q  <= 1'b0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      auto_q   <= auto_d;
      period_q <= period_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      exp_q    <= exp_d;
      raise_q  <= raise_d;
      out_q    <= out_d;
      drive_q  <= drive_d;
    end
  end

  assign BUS_DATA            = drive_q ? out_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer with PRESCALE=4. BUS_DATA carries pullups, so a
// released bus reads 8'hFF.
module tb_bus_timer;

  localparam logic [7:0] IDLE   = 8'h10;
  localparam logic [7:0] A_CTRL = 8'hF0;
  localparam logic [7:0] A_PER  = 8'hF1;
  localparam logic [7:0] A_CNT  = 8'hF2;
  localparam logic [7:0] A_STAT = 8'hF3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = IDLE;
  logic       we = 1'b0;
  logic       ack = 1'b0;
  logic       raise;
  logic [7:0] tb_data = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] bus_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  assign bus_data = tb_drv ? tb_data : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus_data[g]);
  end

  always #5 clk = ~clk;

  bus_timer #(
    .BASE_ADDR     (8'hF0),
    .PRESCALE      (4),
    .PRESCALE_WIDTH(3)
  ) dut (
    .CLK                (clk),
    .RESET              (rst_n),
    .BUS_DATA           (bus_data),
    .BUS_ADDR           (addr),
    .BUS_WE             (we),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack)
  );

  // Write lands on the posedge this task waits for; returns 1 time unit after it.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; we = 1'b1; tb_data = d; tb_drv = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; tb_drv = 1'b0; addr = IDLE;
  endtask

  // Data sampled after the first edge; a second idle edge releases the bus.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; we = 1'b0;
    @(posedge clk);
    #1;
    d = bus_data;
    @(negedge clk);
    addr = IDLE;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, e;
    logic [7:0] regs[4];
    regs[0] = A_CTRL; regs[1] = A_PER; regs[2] = A_CNT; regs[3] = A_STAT;
    wait_edges(2);
    n_checks++;
    if (raise !== 1'b0 || bus_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_hold: raise=%b bus=%h, required raise=0 bus=ff", raise, bus_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h00);
      bus_read(regs[i], got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] got, e;
    bus_write(A_PER, 8'h03);
    bus_write(A_CTRL, 8'h07);  // E0
    wait_edges(11);
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic_e11_raise: got %b required 0", raise);
    end
    wait_edges(1);             // E12
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL periodic_e12_raise: got %b required 1", raise);
    end
    exp_q.push_back(8'h00);
    bus_read(A_CNT, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL periodic_count: got %h required %h", got, e);
    end
  endtask

  task automatic test_ack_status();
    logic [7:0] got, e;
    bus_write(A_CTRL, 8'h06);  // stop, keep IRQ_EN: RAISE must hold
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_hold_before: got %b required 1", raise);
    end
    ack_pulse();
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_clear: got %b required 0", raise);
    end
    exp_q.push_back(8'h01);
    bus_read(A_STAT, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL status_sticky: got %h required %h", got, e);
    end
    bus_write(A_STAT, 8'h01);
    exp_q.push_back(8'h00);
    bus_read(A_STAT, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL status_w1c: got %h required %h", got, e);
    end
    ack_pulse();
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle_ignored: got %b required 0", raise);
    end
  endtask

  task automatic test_bus_window();
    @(negedge clk);
    addr = A_PER; we = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_data !== 8'h03) begin
      n_fail++;
      $display("FAIL window_read: got %h required 03", bus_data);
    end
    @(negedge clk);
    addr = IDLE;
    #1;
    n_checks++;
    if (bus_data !== 8'h03) begin
      n_fail++;
      $display("FAIL window_hold: got %h required 03", bus_data);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL window_release: got %h required ff (released)", bus_data);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] got, e;
    logic       saw;
    bus_write(A_PER, 8'h02);
    bus_write(A_CTRL, 8'h03);  // E0
    wait_edges(7);
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_e7_raise: got %b required 0", raise);
    end
    wait_edges(1);
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_e8_raise: got %b required 1", raise);
    end
    ack_pulse();
    exp_q.push_back(8'h02);
    bus_read(A_CTRL, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL oneshot_ctrl: got %h required %h", got, e);
    end
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (raise) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_no_rearm: saw raise=%b required 0", saw);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, e;
    bus_write(A_PER, 8'h01);
    bus_write(A_CTRL, 8'h07);  // E0, expiries every 4 edges
    wait_edges(4);
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_e4_raise: got %b required 1", raise);
    end
    wait_edges(3);
    ack_pulse();               // sampled at E8, an expiry edge
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_ack_vs_expiry: got %b required 1", raise);
    end
    ack_pulse();               // E9
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_ack_e9: got %b required 0", raise);
    end
    wait_edges(2);
    bus_write(A_STAT, 8'h01);  // E12, expiry edge
    exp_q.push_back(8'h01);
    bus_read(A_STAT, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL sim_w1c_vs_expiry: got %h required %h", got, e);
    end
    bus_write(A_CTRL, 8'h00);
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_en_clear: got %b required 0", raise);
    end
    // COUNT write coincident with an expiring tick suppresses the expiry.
    bus_write(A_STAT, 8'h01);
    bus_write(A_CTRL, 8'h05);  // G0
    wait_edges(3);
    bus_write(A_CNT, 8'h55);   // G4
    exp_q.push_back(8'h00);
    bus_read(A_STAT, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL count_write_vs_tick: got %h required %h", got, e);
    end
    wait_edges(2);             // G8 expiry
    exp_q.push_back(8'h01);
    bus_read(A_STAT, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL count_write_resume: got %h required %h", got, e);
    end
  endtask

  task automatic test_period_zero();
    bus_write(A_CTRL, 8'h00);
    bus_write(A_PER, 8'h00);
    bus_write(A_STAT, 8'h01);
    bus_write(A_CTRL, 8'h07);  // F0
    wait_edges(1023);
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL p0_1023: got %b required 0", raise);
    end
    wait_edges(1);
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_1024: got %b required 1", raise);
    end
    ack_pulse();               // F0+1025
    wait_edges(1022);
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL p0_2047: got %b required 0", raise);
    end
    wait_edges(1);
    n_checks++;
    if (raise !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_2048: got %b required 1", raise);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] got, e;
    logic [7:0] regs[4];
    regs[0] = A_CTRL; regs[1] = A_PER; regs[2] = A_CNT; regs[3] = A_STAT;
    @(negedge clk);
    addr = A_STAT; we = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_data !== 8'h01) begin
      n_fail++;
      $display("FAIL midop_read_active: got %h required 01", bus_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (raise !== 1'b0 || bus_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL midop_async: raise=%b bus=%h, required raise=0 bus=ff", raise, bus_data);
    end
    @(negedge clk);
    addr = IDLE;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h00);
      bus_read(regs[i], got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL midop_reg%0d: got %h required %h", i, got, e);
      end
    end
    n_checks++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_raise_after: got %b required 0", raise);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_periodic();
    test_ack_status();
    test_bus_window();
    test_one_shot();
    test_simultaneous();
    test_period_zero();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
